multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle main control FSM for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Its inputs are the instruction fields produced by the instruction-field parser from the registered instruction register (IR). It drives every enable and mux select of the shared datapath (PC, IR, register file, ALU, unified memory port) and counts retired instructions.

## Interface
- `RESET_PC_WRITE`, default 0: when 1, `pc_write` is asserted for one cycle on the first FETCH after reset to load the reset vector.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: IR[6:0] from the parser.
- `funct3` input 3: IR[14:12].
- `funct7` input 7: IR[31:25].
- `zero` input 1: ALU result-equals-zero flag.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request valid.
- `mem_we` output 1: request is a write.
- `addr_src` output 1: memory address source; 0 = PC, 1 = ALU-out register.
- `ir_write` output 1: load IR from memory read data.
- `pc_write` output 1: load PC.
- `pc_src` output 2: PC source; 0 = ALU result (PC+4), 1 = ALU-out register (branch/JAL target).
- `reg_write` output 1: register-file write enable.
- `result_src` output 2: writeback source; 0 = ALU-out, 1 = memory data, 2 = immediate (LUI), 3 = PC+4.
- `alu_src_a` output 2: ALU A operand; 0 = PC, 1 = old PC, 2 = rs1.
- `alu_src_b` output 2: ALU B operand; 0 = rs2, 1 = immediate, 2 = constant 4.
- `alu_ctrl` output 4: ALU operation; 0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = XOR, 5 = SLT, 6 = SLL, 7 = SRL, 8 = SRA.
- `state` output 4: current state, for debug.
- `illegal` output 1: sticky illegal-instruction flag.
- `instret` output 32: retired-instruction count.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5.
  - EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, LUI = 11, TRAP = 12.
  - Encodings 13–15 fall through to TRAP.
- FETCH:
  - `mem_req`=1, `addr_src`=0, `alu_src_a`=0, `alu_src_b`=2, ADD.
  - Hold while `mem_ready`=0.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, go to DECODE.
- DECODE:
  - Computes old PC + immediate (`alu_src_a`=1, `alu_src_b`=1, ADD) into ALU-out.
  - Dispatch on `opcode`:
    - 0110011 goes to EXECR.
    - 0010011 goes to EXECI.
    - 0000011 (`funct3`=010) and 0100011 (`funct3`=010) go to MEMADR.
    - 1100011 with `funct3` ∈ {000, 001} goes to BRANCH.
    - 1101111 goes to JAL.
    - 0110111 goes to LUI.
    - Anything else goes to TRAP.
  - R-type with `funct7` not in {0000000, 0100000} goes to TRAP.
- MEMADR: rs1 + immediate (ADD). Then MEMREAD if the opcode is a load, else MEMWRITE.
- MEMREAD: `mem_req`=1, `addr_src`=1; hold until `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `result_src`=1; retire; go to FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `addr_src`=1; hold until `mem_ready`, then retire and go to FETCH.
- EXECR / EXECI:
  - `alu_src_a`=2; `alu_src_b`=0 (EXECR) or 1 (EXECI).
  - `alu_ctrl` comes from the ALU decoder. `funct7[5]` selects SUB/SRA; for I-type it selects SRA only.
  - Then ALUWB.
- ALUWB: `reg_write`=1, `result_src`=0; retire; go to FETCH.
- BRANCH:
  - rs1 − rs2 (SUB), `pc_src`=1.
  - `pc_write` = (`funct3`=000 & `zero`) | (`funct3`=001 & !`zero`).
  - Retire; go to FETCH.
- JAL: `reg_write`=1, `result_src`=3, `pc_write`=1, `pc_src`=1; retire; go to FETCH.
- LUI: `reg_write`=1, `result_src`=2; retire; go to FETCH.
- TRAP: all enables 0, `illegal`=1; stay in TRAP until reset.
- `instret`:
  - Increments by 1 on each retire cycle.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not increment in TRAP.

## Timing
- Reset, asynchronous:
  - `state`=FETCH, `illegal`=0, `instret`=0.
  - All enables 0 while `reset_n`=0.
  - Asserting reset mid-transaction abandons it. No write completes after reset is asserted.
- Control outputs are Moore decodes of `state`. Exception: `ir_write`/`pc_write` in FETCH and the memory-state exits are additionally qualified by `mem_ready` in the same cycle.
- `opcode`, `funct3`, `funct7` are sampled only from DECODE onward; they are don't-care in FETCH.
- Latency with `mem_ready` tied high:
  - Branch, JAL, LUI: 3 cycles.
  - R/I-ALU, store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- `mem_req` stays high and the request is stable until the `mem_ready` cycle.
- `mem_ready` is ignored outside the memory states.
- `pc_write` (BRANCH/JAL) and `reg_write` are single-cycle pulses.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - state encodings, opcode constants, `alu_ctrl` codes;
  - `result_src`, `alu_src_a`, `alu_src_b`, `pc_src` select codes.
- One sub-module: `alu_decoder`, combinational. Inputs are `alu_op` class (ADD/SUB/FUNCT), `funct3`, `funct7[5]`, and an is-R-type bit; output is `alu_ctrl`.

## Test plan
- `add` (0x003100B3), `mem_ready`=1 → states 0,1,6,8,0. `reg_write` high only in ALUWB; `alu_ctrl`=ADD in EXECR; `instret`=1.
- `lw` (0x0000A103) with FETCH and MEMREAD each stalled 2 cycles → 9 cycles total. `mem_req` is continuous in each memory state; `reg_write` with `result_src`=1 occurs once.
- `beq` (0x00208463):
  - `zero`=1 → `pc_write` pulse in BRANCH with `pc_src`=1.
  - `zero`=0 → no pulse.
  - `bne` gives the inverse.
- Opcode 0x7F and R-type `funct7`=0x01 → TRAP after DECODE. `illegal`=1 and stays 1 through 100 cycles; no further `mem_req`.
- `reset_n` dropped during MEMWRITE wait → `mem_req`/`mem_we` fall immediately. After release: FETCH, `instret`=0.
- `instret` forced near wrap by executing `lui` until the count passes 0xFFFFFFFF → count rolls to 0 on the next retire.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: FSM states, opcodes,
// ALU operation codes, datapath mux selects and the DECODE dispatch helper.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic       ADDR_PC      = 1'b0;
    localparam logic       ADDR_ALUOUT  = 1'b1;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

    localparam logic [1:0] RES_ALUOUT   = 2'd0;
    localparam logic [1:0] RES_MEM      = 2'd1;
    localparam logic [1:0] RES_IMM      = 2'd2;
    localparam logic [1:0] RES_PC4      = 2'd3;

    localparam logic [1:0] SRCA_PC      = 2'd0;
    localparam logic [1:0] SRCA_OLDPC   = 2'd1;
    localparam logic [1:0] SRCA_RS1     = 2'd2;

    localparam logic [1:0] SRCB_RS2     = 2'd0;
    localparam logic [1:0] SRCB_IMM     = 2'd1;
    localparam logic [1:0] SRCB_FOUR    = 2'd2;

    // Anything not explicitly supported lands in TRAP.
    function automatic state_t dispatch(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
        state_t s;
        s = S_TRAP;
        case (op)
            OP_RTYPE:          if (f7 == 7'b0000000 || f7 == 7'b0100000) s = S_EXECR;
            OP_ITYPE:          s = S_EXECI;
            OP_LOAD, OP_STORE: if (f3 == F3_WORD) s = S_MEMADR;
            OP_BRANCH:         if (f3 == F3_BEQ || f3 == F3_BNE) s = S_BRANCH;
            OP_JAL:            s = S_JAL;
            OP_LUI:            s = S_LUI;
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM and the shared datapath / unified memory port.
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;

    // Memory handshake: mem_req is the valid; mem_req, mem_we and addr_src stay
    // stable until the cycle mem_ready is high, which completes the request.
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;

    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               reg_write, result_src, alu_src_a, alu_src_b, alu_ctrl
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
               reg_write, result_src, alu_src_a, alu_src_b, alu_ctrl
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the control-path ALU operation class plus funct fields to an ALU op code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // ADDI never subtracts; imm[10] only means something for shifts.
                    3'b000:  alu_ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    // The ALU has no unsigned compare, so SLTU shares the SLT code.
                    3'b010,
                    3'b011:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences one instruction at a
// time, drives every datapath enable/select and counts retired instructions.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic [31:0]          instret
);

    state_t      state_q;
    state_t      state_d;
    logic        boot_q;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;
    alu_op_t     alu_op;
    logic        is_rtype;
    logic [3:0]  alu_ctrl;

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op),
        .funct3    (bus.funct3),
        .funct7_b5 (bus.funct7[5]),
        .is_rtype  (is_rtype),
        .alu_ctrl  (alu_ctrl)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            // The boot cycle loads the reset vector, so no fetch is issued in it.
            S_FETCH:    if (!boot_q && bus.mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = dispatch(bus.opcode, bus.funct3, bus.funct7);
            S_MEMADR: begin
                if (bus.opcode == OP_LOAD) state_d = S_MEMREAD;
                else                       state_d = S_MEMWRITE;
            end
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_LUI: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            boot_q    <= RESET_PC_WRITE;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            boot_q  <= 1'b0;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
            if (retire)            instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.addr_src   = ADDR_PC;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PCSRC_ALU;
        bus.reg_write  = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        alu_op         = ALUOP_ADD;
        is_rtype       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = !boot_q;
                bus.ir_write  = !boot_q && bus.mem_ready;
                bus.pc_write  = boot_q || bus.mem_ready;
                bus.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.mem_req  = 1'b1;
                bus.addr_src = ADDR_ALUOUT;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.addr_src = ADDR_ALUOUT;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                alu_op        = ALUOP_FUNCT;
                is_rtype      = 1'b1;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
            end
            S_ALUWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                bus.pc_write  = ((bus.funct3 == F3_BEQ) && bus.zero) ||
                                ((bus.funct3 == F3_BNE) && !bus.zero);
            end
            S_JAL: begin
                bus.reg_write  = 1'b1;
                bus.result_src = RES_PC4;
                bus.pc_write   = 1'b1;
                bus.pc_src     = PCSRC_ALUOUT;
            end
            S_LUI: begin
                bus.reg_write  = 1'b1;
                bus.result_src = RES_IMM;
            end
            default: ;
        endcase
        // Reset abandons any transaction in flight: nothing may write while held.
        if (!reset_n) begin
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.alu_ctrl = alu_ctrl;
    assign state        = state_q;
    assign illegal      = illegal_q;
    assign instret      = instret_q;

endmodule
